if_fetch_stage: RTL and testbench
=================================

// Module: if_fetch_stage
// PURPOSE
//  Instruction-fetch stage: owns the PC, fetches words from instruction memory
//  over a single-outstanding req/rvalid handshake, and presents {PC+4, instr} to
//  the IF/ID pipeline register.
//  Honours pipeline stall and branch/jump redirects; supplies NOP (32'h0) bubbles
//  whenever no fetched word is ready.
// PARAMETERS
//  RESET_PC  32'h0000_0000  fetch address loaded on reset
//  CNT_W     32             width of perf counters (used only with IF_PERF_CNT_EN)
// PORTS
//  clk              in   1   clock, rising edge
//  reset            in   1   synchronous, active-high
//  stall_i          in   1   hazard unit: IF/ID holds, buffered word not consumed
//  redirect_i       in   1   branch/jump taken; same cycle as IF/ID flush
//  redirect_pc_i    in   32  redirect target; bits [1:0] ignored (forced 2'b00)
//  imem_req_o       out  1   one-cycle request pulse
//  imem_addr_o      out  32  word address; valid while imem_req_o=1
//  imem_rvalid_i    in   1   response strobe, >=1 cycle after the request
//  imem_rdata_i     in   32  instruction word, valid with imem_rvalid_i
//  instr_o          out  32  to IF/ID instr_in; 32'h0 when instr_valid_o=0
//  pc_plus_4_o      out  32  to IF/ID PC_plus_4in; 32'h0 when instr_valid_o=0
//  instr_valid_o    out  1   buffered instruction present
//  perf_fetch_o     out  CNT_W  instructions consumed (IF_PERF_CNT_EN only)
//  perf_bubble_o    out  CNT_W  cycles with instr_valid_o=0 (IF_PERF_CNT_EN only)
// BEHAVIOUR
//  - Reset: state=REQ, pc=RESET_PC, valid=0, discard=0; instr_o/pc_plus_4_o=0.
//    imem_req_o forced 0 while reset=1. Imem shares the reset; no stale responses.
//  - States: REQ, WAIT, HOLD.
//    REQ:  imem_req_o=1, addr=pc -> WAIT.
//    WAIT: on rvalid with discard=0: buf<=rdata, buf_pc4<=pc+4, pc<=pc+4,
//          valid<=1 -> HOLD. On rvalid with discard=1: discard<=0, drop data -> REQ.
//    HOLD: valid=1. If stall_i=1: stay, outputs frozen. If stall_i=0: word consumed
//          this edge; imem_req_o=1 with addr=pc in the same cycle; valid<=0 -> WAIT.
//  - Best throughput with 1-cycle imem: one instruction every 2 cycles.
//  - Redirect has priority over stall_i and all transitions: pc<=redirect_pc & ~3,
//    valid<=0, no imem_req_o that cycle.
//    In WAIT without rvalid: discard<=1, stay WAIT. In WAIT with rvalid: drop data -> REQ.
//    In REQ or HOLD: -> REQ.
//  - Address arithmetic is modulo 2^32; 32'hFFFF_FFFC + 4 wraps to 32'h0.
//  - Never more than one request outstanding; no request while discard=1 before rvalid.
//  - rvalid in REQ/HOLD is a protocol error: ignored; assertion fires in simulation.
// CONFIGURATION
//  IF_PERF_CNT_EN defined: perf_fetch_o increments per HOLD && !stall_i && !redirect_i;
//    perf_bubble_o increments per cycle with valid=0 and reset=0.
//    Both reset to 0 and wrap at 2^CNT_W.
//  Undefined: perf ports absent from the port list; no counter logic.
// STRUCTURE
//  mips_pkg: fetch_state_t enum {REQ,WAIT,HOLD}, NOP_INSTR=32'h0,
//    DEFAULT_RESET_PC; shared beside ctrl_t/idex_data_t.
//  Sub-module if_perf_counters (two CNT_W counters), instantiated only under
//  IF_PERF_CNT_EN. FSM, PC and output buffer stay inline.
// TESTING
//  1 Reset release, imem 1-cycle latency, stall_i=0 -> addrs 0,4,8; outputs
//    {4,I0},{8,I1},{12,I2} valid every 2nd cycle.
//  2 HOLD with instr I0 and stall_i=1 for 3 cycles -> instr_o/pc_plus_4_o frozen,
//    no imem_req_o; next req 1 cycle after stall drops.
//  3 Redirect to 32'h0000_0103 while WAIT (3-cycle imem) -> old rdata dropped,
//    next req addr 32'h100, first valid pc_plus_4_o=32'h104.
//  4 Redirect in the same cycle as rvalid -> data dropped, REQ next cycle,
//    instr_valid_o stays 0.
//  5 pc=32'hFFFF_FFFC fetch -> pc_plus_4_o=32'h0, next addr 32'h0.
//  6 Reset asserted mid-WAIT -> next cycle valid=0, outputs 0; first req at RESET_PC.
//    With IF_PERF_CNT_EN: counters read 0.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mips_pkg
//  Purpose  : Shared pipeline types and constants for the MIPS core.
//  Revision : 1.0 - initial release
// ============================================================================
package mips_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic       reg_write;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       alu_src;
    logic       reg_dst;
    logic [1:0] alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] pc_plus_4;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [4:0]  rt;
    logic [4:0]  rd;
  } idex_data_t;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage
`default_nettype wire

// File: rtl/if_perf_counters.sv
`default_nettype none
// ============================================================================
//  Module   : if_perf_counters
//  Purpose  : Two free-running wrap-around event counters for the fetch stage.
//  Revision : 1.0 - initial release
// ============================================================================
module if_perf_counters #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             fetch_inc_i,
  input  logic             bubble_inc_i,
  output logic [CNT_W-1:0] fetch_cnt_o,
  output logic [CNT_W-1:0] bubble_cnt_o
);

  logic [CNT_W-1:0] fetch_cnt_q,  fetch_cnt_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;

  always_comb begin
    fetch_cnt_d  = fetch_cnt_q;
    bubble_cnt_d = bubble_cnt_q;
    if (fetch_inc_i)  fetch_cnt_d  = fetch_cnt_q + 1'b1;
    if (bubble_inc_i) bubble_cnt_d = bubble_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      fetch_cnt_q  <= fetch_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign fetch_cnt_o  = fetch_cnt_q;
  assign bubble_cnt_o = bubble_cnt_q;

endmodule
`default_nettype wire

// File: rtl/if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : if_fetch_stage
//  Purpose  : Instruction fetch: PC, single-outstanding imem handshake and the
//             buffered {PC+4, instr} word feeding IF/ID. Optional performance
//             counters are built when IF_PERF_CNT_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module if_fetch_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
`ifdef IF_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  output logic [31:0] instr_o,
  output logic [31:0] pc_plus_4_o,
  output logic        instr_valid_o
`ifdef IF_PERF_CNT_EN
  , output logic [CNT_W-1:0] perf_fetch_o
  , output logic [CNT_W-1:0] perf_bubble_o
`endif
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  buf_pc4_q, buf_pc4_d;
  logic         valid_q, valid_d;
  logic         discard_q, discard_d;
  logic [31:0]  pc_plus_4;

  assign pc_plus_4 = pc_q + 32'd4;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    buf_d     = buf_q;
    buf_pc4_d = buf_pc4_q;
    valid_d   = valid_q;
    discard_d = discard_q;
    if (redirect_i) begin
      pc_d    = word_align(redirect_pc_i);
      valid_d = 1'b0;
      // A request still in flight must have its response swallowed later.
      if (state_q == WAIT) begin
        if (imem_rvalid_i) begin
          discard_d = 1'b0;
          state_d   = REQ;
        end else begin
          discard_d = 1'b1;
          state_d   = WAIT;
        end
      end else begin
        state_d = REQ;
      end
    end else begin
      case (state_q)
        REQ:  state_d = WAIT;
        WAIT: begin
          if (imem_rvalid_i) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = REQ;
            end else begin
              buf_d     = imem_rdata_i;
              buf_pc4_d = pc_plus_4;
              pc_d      = pc_plus_4;
              valid_d   = 1'b1;
              state_d   = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_i) begin
            valid_d = 1'b0;
            state_d = WAIT;
          end
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= REQ;
      pc_q      <= RESET_PC;
      buf_q     <= NOP_INSTR;
      buf_pc4_q <= 32'h0;
      valid_q   <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      buf_q     <= buf_d;
      buf_pc4_q <= buf_pc4_d;
      valid_q   <= valid_d;
      discard_q <= discard_d;
    end
  end

  // Consuming the HOLD word and issuing the next request share one cycle.
  assign imem_req_o    = !reset && !redirect_i &&
                         ((state_q == REQ) || ((state_q == HOLD) && !stall_i));
  assign imem_addr_o   = pc_q;
  assign instr_valid_o = valid_q;
  assign instr_o       = valid_q ? buf_q     : NOP_INSTR;
  assign pc_plus_4_o   = valid_q ? buf_pc4_q : 32'h0;

`ifdef IF_PERF_CNT_EN
  logic fetch_inc;
  logic bubble_inc;

  assign fetch_inc  = (state_q == HOLD) && !stall_i && !redirect_i;
  assign bubble_inc = !valid_q;

  if_perf_counters #(
    .CNT_W (CNT_W)
  ) u_perf (
    .clk          (clk),
    .reset        (reset),
    .fetch_inc_i  (fetch_inc),
    .bubble_inc_i (bubble_inc),
    .fetch_cnt_o  (perf_fetch_o),
    .bubble_cnt_o (perf_bubble_o)
  );
`endif

  a_rvalid_only_in_wait: assert property (@(posedge clk) disable iff (reset)
    imem_rvalid_i |-> (state_q == WAIT));

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_stage.sv
`default_nettype none
// ============================================================================
//  Module   : tb_if_fetch_stage
//  Purpose  : Directed self-checking bench for if_fetch_stage with a simple
//             variable-latency instruction memory responder.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_if_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic [31:0] instr_o;
  logic [31:0] pc_plus_4_o;
  logic        instr_valid_o;
`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_fetch_o;
  logic [31:0] perf_bubble_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  // imem responder state
  int          lat   = 1;
  int          cnt   = 0;
  logic        pend  = 1'b0;
  logic [31:0] paddr = 32'h0;

  if_fetch_stage dut (
    .clk           (clk),
    .reset         (reset),
    .stall_i       (stall_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .instr_o       (instr_o),
    .pc_plus_4_o   (pc_plus_4_o),
    .instr_valid_o (instr_valid_o)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_o  (perf_fetch_o)
    , .perf_bubble_o (perf_bubble_o)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance one clock; the memory answers requests seen before the edge.
  task automatic tick();
    logic        req_s;
    logic        rst_s;
    logic [31:0] addr_s;
    req_s  = imem_req_o;
    addr_s = imem_addr_o;
    rst_s  = reset;
    @(posedge clk);
    #1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    if (rst_s) begin
      pend = 1'b0;
    end else begin
      if (req_s) begin
        pend  = 1'b1;
        cnt   = lat;
        paddr = addr_s;
      end
      if (pend) begin
        cnt--;
        if (cnt == 0) begin
          imem_rvalid_i = 1'b1;
          imem_rdata_i  = word(paddr);
          pend          = 1'b0;
        end
      end
    end
    #1;
  endtask

  initial begin
    reset         = 1'b1;
    stall_i       = 1'b0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;

    tick(); tick();
    check("rst_req",   {31'h0, imem_req_o},    32'h0);
    check("rst_valid", {31'h0, instr_valid_o}, 32'h0);
    check("rst_instr", instr_o,                32'h0);
    check("rst_pc4",   pc_plus_4_o,            32'h0);

    // 1: streaming fetch, 1-cycle imem
    reset = 1'b0; #1;
    check("t1_req0",  {31'h0, imem_req_o}, 32'h1);
    check("t1_addr0", imem_addr_o,         32'h0);
    tick();
    check("t1_wait_valid", {31'h0, instr_valid_o}, 32'h0);
    check("t1_wait_req",   {31'h0, imem_req_o},    32'h0);
    tick();
    check("t1_i0",     instr_o,     32'hA500_0000);
    check("t1_i0_pc4", pc_plus_4_o, 32'h4);
    check("t1_addr1",  imem_addr_o, 32'h4);
    check("t1_req1",   {31'h0, imem_req_o}, 32'h1);
    tick();
    check("t1_bubble", instr_o, 32'h0);
    tick();
    check("t1_i1",     instr_o,     32'hA500_0004);
    check("t1_i1_pc4", pc_plus_4_o, 32'h8);
    check("t1_addr2",  imem_addr_o, 32'h8);
    tick(); tick();
    check("t1_i2",     instr_o,     32'hA500_0008);
    check("t1_i2_pc4", pc_plus_4_o, 32'hC);

    // 2: stall for three cycles in HOLD
    stall_i = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      check("t2_req_stall", {31'h0, imem_req_o},    32'h0);
      check("t2_valid",     {31'h0, instr_valid_o}, 32'h1);
      check("t2_instr",     instr_o,                32'hA500_0008);
      check("t2_pc4",       pc_plus_4_o,            32'hC);
      tick();
    end
    stall_i = 1'b0; #1;
    check("t2_req_after", {31'h0, imem_req_o}, 32'h1);
    check("t2_addr_after", imem_addr_o,        32'hC);
    lat = 3;
    tick();

    // 3: redirect while waiting on a 3-cycle imem
    redirect_i = 1'b1; redirect_pc_i = 32'h0000_0103; #1;
    check("t3_no_req", {31'h0, imem_req_o}, 32'h0);
    tick();
    redirect_i = 1'b0; #1;
    check("t3_discard_req", {31'h0, imem_req_o}, 32'h0);
    tick();
    check("t3_drop_valid", {31'h0, instr_valid_o}, 32'h0);
    tick();
    check("t3_req",  {31'h0, imem_req_o}, 32'h1);
    check("t3_addr", imem_addr_o,         32'h100);
    tick(); tick(); tick(); tick();
    check("t3_valid", {31'h0, instr_valid_o}, 32'h1);
    check("t3_pc4",   pc_plus_4_o,            32'h104);
    check("t3_instr", instr_o,                32'hA500_0100);
    lat = 1;
    tick();

    // 4: redirect coincident with rvalid; target also sets up 5
    check("t4_rvalid_now", {31'h0, imem_rvalid_i}, 32'h1);
    redirect_i = 1'b1; redirect_pc_i = 32'hFFFF_FFFC; #1;
    check("t4_no_req", {31'h0, imem_req_o}, 32'h0);
    tick();
    redirect_i = 1'b0; #1;
    check("t4_valid0", {31'h0, instr_valid_o}, 32'h0);
    check("t4_req",    {31'h0, imem_req_o},    32'h1);
    check("t4_addr",   imem_addr_o,            32'hFFFF_FFFC);

    // 5: address wrap
    tick();
    check("t5_wait_valid", {31'h0, instr_valid_o}, 32'h0);
    lat = 3;
    tick();
    check("t5_instr", instr_o,     32'hA5FF_FFFC);
    check("t5_pc4",   pc_plus_4_o, 32'h0);
    check("t5_addr",  imem_addr_o, 32'h0);
    tick();

    // 6: reset asserted mid-WAIT
    reset = 1'b1; #1;
    check("t6_req_in_reset", {31'h0, imem_req_o}, 32'h0);
    tick();
    reset = 1'b0; #1;
    check("t6_valid", {31'h0, instr_valid_o}, 32'h0);
    check("t6_instr", instr_o,                32'h0);
    check("t6_pc4",   pc_plus_4_o,            32'h0);
    check("t6_req",   {31'h0, imem_req_o},    32'h1);
    check("t6_addr",  imem_addr_o,            32'h0);
`ifdef IF_PERF_CNT_EN
    check("t6_perf_fetch",  perf_fetch_o,  32'h0);
    check("t6_perf_bubble", perf_bubble_o, 32'h0);
`endif
    tick(); tick();
    check("t6_no_stale", {31'h0, imem_rvalid_i}, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
